imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the fetch request interface: the memory-side end of the `Addr`/`req_valid`/`grant`/`Data`/`data_valid` handshake that the fetch stage initiates. It accepts one fetch request at a time and pulses `grant`. After a fixed programmable latency it returns the addressed 32-bit instruction word and holds it until the fetch stage drops its request. It sits between the core fetch port and the instruction storage, yielding to the MMU/data side via `mmu_busy`, and includes a backdoor load port for program preload.

## Interface
- `ADDR_WIDTH`, 32, byte-address width (matches system `ADDR_WIDTH`)
- `DATA_WIDTH`, 32, instruction word width
- `MEM_DEPTH`, 1024, memory size in bytes; the valid byte range is 0 .. MEM_DEPTH-1; must be a multiple of 4
- `LATENCY`, 2, cycles from `grant` to the first `data_valid`; legal range ≥1
- `clk` in 1 clock
- `reset` in 1 synchronous, active-high
- `req_valid` in 1 fetch request
- `addr` in ADDR_WIDTH byte address of the instruction
- `grant` out 1 one-cycle pulse: request accepted
- `data` out DATA_WIDTH returned instruction
- `data_valid` out 1 response valid, held until released
- `rsp_err` out 1 qualifies `data_valid`: the address was out of range or misaligned
- `flush` in 1 cancels any in-flight request (tied to system flush / branch taken)
- `mmu_busy` in 1 the arbiter is serving the MMU; no new acceptance
- `ld_we` in 1 backdoor write enable
- `ld_addr` in clog2(MEM_DEPTH/4) word index
- `ld_data` in DATA_WIDTH backdoor write data

## Operation
- FSM states: IDLE, GRANT, BUSY, RESP.
- **IDLE**
  - If `req_valid && !mmu_busy && !flush`, latch `addr` into `addr_q` and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `grant`=1 for exactly this cycle.
  - Load `busy_cnt`=LATENCY and go to BUSY.
- **BUSY**
  - `busy_cnt` decrements each cycle.
  - When `busy_cnt`==1: read the array at `addr_q[clog2(MEM_DEPTH)-1:2]`, register the word into `data`, and go to RESP.
- **RESP**
  - `data_valid`=1 and `data` is held stable.
  - On `!req_valid`: go to IDLE, with `data_valid`=0 from the next cycle.
  - A new request is accepted only from IDLE. There is a minimum one-cycle bubble after RESP.
- **Error responses**
  - Trigger: `addr_q >= MEM_DEPTH` or `addr_q[1:0] != 0`.
  - Response: `data` = NOP 32'h0000_0013 and `rsp_err`=1, with the same timing as a normal response.
  - `rsp_err`=0 whenever `data_valid`=0.
- **Flush**
  - Asserted in GRANT, BUSY or RESP: next state is IDLE, and `grant`/`data_valid` are 0 from the next cycle.
  - Flush has priority over every other transition.
  - Asserted in IDLE: blocks acceptance that cycle.
- `mmu_busy` only gates acceptance in IDLE. It never aborts a granted request.
- **Backdoor write**
  - Occurs at the clk edge whenever `ld_we`=1, in any state.
  - An array read on the same edge as a write to the same word returns the old data (read-before-write).
- **Reset**
  - FSM to IDLE, `busy_cnt`=0.
  - Outputs: `grant`=0, `data_valid`=0, `rsp_err`=0, `data`=0.
  - Array contents are not cleared by reset.
  - Reset mid-transaction drops the transaction silently; no response is issued.

## Timing
- Request sampled in IDLE at cycle N:
  - `grant` is high at N+1.
  - `data_valid` is first high at N+1+LATENCY (N+3 with the default).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `data_valid` deasserts one cycle after `req_valid` is sampled low in RESP. This matches the fetch stage dropping `req_valid` the cycle after it consumes the data.
- Sustained throughput: one instruction per LATENCY+3 cycles.

## Structure
- Shared include (`system_param.vh`):
  - `ADDR_WIDTH`, `DATA_WIDTH`, `MEM_DEPTH`
  - `NOP_INST` (32'h0000_0013)
  - responder state encodings `IMR_IDLE`/`IMR_GRANT`/`IMR_BUSY`/`IMR_RESP` (2 bits)
- Sub-module `imem_array`:
  - word-organised storage, MEM_DEPTH/4 entries
  - registered read port (`rd_en`, `rd_idx`, `rd_data`)
  - independent write port driven by the backdoor signals
- The top level holds the FSM, latency counter, address latch, error decode and output registers.

## Test plan
- Preload word 5 = 32'hDEAD_BEEF; request `addr`=0x14 at cycle 10 with LATENCY=2 → `grant` pulses at cycle 11; `data_valid`=1 with `data`=0xDEADBEEF and `rsp_err`=0 from cycle 13; drop `req_valid` at 15 → `data_valid`=0 at 16.
- `mmu_busy`=1 for cycles 10–14 with `req_valid` high from 10 → no `grant` until cycle 16; response at cycle 18.
- `flush` in BUSY (cycle after `grant`) → no `data_valid`; FSM in IDLE; the next request is granted normally one cycle after sampling.
- `addr`=MEM_DEPTH (0x400) and `addr`=0x02 → `data`=0x00000013 and `rsp_err`=1 for each, with normal timing.
- Backdoor write of 0x1234_5678 to word 3 on the same edge the array reads word 3 → response returns the old value; a repeat request returns 0x12345678.
- `reset` asserted in RESP → `data_valid`=0 next cycle and FSM in IDLE; with LATENCY=1, `grant` at N+1 and `data_valid` at N+2.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared widths, NOP encoding and responder state encodings.
package imem_responder_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMR_IDLE  = 2'd0,
        IMR_GRANT = 2'd1,
        IMR_BUSY  = 2'd2,
        IMR_RESP  = 2'd3
    } imr_state_e;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake between fetch stage and instruction memory.
interface imem_responder_if
    import imem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  grant;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  rsp_err;

    modport master (output req_valid, addr, input grant, data, data_valid, rsp_err);
    modport slave  (input req_valid, addr, output grant, data, data_valid, rsp_err);
endinterface

// File: rtl/imem_responder_array.sv
// imem_responder_array: word-organised instruction storage, registered read port, independent write port.
module imem_responder_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 256,
    localparam int IW        = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [IW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    // Storage is deliberately left out of reset so preloaded programs survive it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else if (rd_en) rd_data <= mem_q[rd_idx];
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory-side fetch responder; one request at a time, fixed latency, held response.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int LATENCY    = 2,
    localparam int IW        = $clog2(MEM_DEPTH / 4)
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       bus,
    input  logic                  flush,
    input  logic                  mmu_busy,
    input  logic                  ld_we,
    input  logic [IW-1:0]         ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);
    localparam int CW = $clog2(LATENCY + 1);

    imr_state_e            state_q;
    logic [CW-1:0]         busy_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  grant_q;
    logic                  dv_q;
    logic                  err_q;
    logic                  rd_en;
    logic                  addr_err;
    logic [DATA_WIDTH-1:0] rd_data;

    // The counter covers the grant cycle too, so the word is fetched on the edge that enters RESP.
    assign rd_en    = (state_q == IMR_GRANT || state_q == IMR_BUSY) && busy_cnt_q == CW'(1) && !flush;
    assign addr_err = addr_q >= ADDR_WIDTH'(MEM_DEPTH) || addr_q[1:0] != 2'b00;

    imem_responder_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (MEM_DEPTH / 4)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_idx  (addr_q[IW+1:2]),
        .rd_data (rd_data),
        .wr_en   (ld_we),
        .wr_idx  (ld_addr),
        .wr_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IMR_IDLE;
            busy_cnt_q <= '0;
            addr_q     <= '0;
            grant_q    <= 1'b0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            grant_q <= 1'b0;
            case (state_q)
                IMR_IDLE: begin
                    if (bus.req_valid && !mmu_busy && !flush) begin
                        addr_q     <= bus.addr;
                        busy_cnt_q <= CW'(LATENCY);
                        grant_q    <= 1'b1;
                        state_q    <= IMR_GRANT;
                    end
                end
                IMR_GRANT, IMR_BUSY: begin
                    busy_cnt_q <= busy_cnt_q - CW'(1);
                    if (flush) begin
                        state_q <= IMR_IDLE;
                    end else if (rd_en) begin
                        state_q <= IMR_RESP;
                        dv_q    <= 1'b1;
                        err_q   <= addr_err;
                    end else begin
                        state_q <= IMR_BUSY;
                    end
                end
                IMR_RESP: begin
                    if (flush || !bus.req_valid) begin
                        state_q <= IMR_IDLE;
                        dv_q    <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IMR_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.data_valid = dv_q;
    assign bus.rsp_err    = err_q;
    assign bus.data       = err_q ? DATA_WIDTH'(NOP_INST) : rd_data;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: vector table plus scoreboard checks of the fetch responder (LATENCY 2 and 1).
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          mmu;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        mmu_busy = 1'b0;
    logic        ld_we = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        dv_prev = 1'b0;
    logic [31:0] model [256];
    exp_t        sb [$];
    vec_t        vecs [9];
    int          total = 0;
    int          bad = 0;

    imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();

    imem_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset), .bus(b1), .flush(flush), .mmu_busy(mmu_busy),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .bus(b2), .flush(flush), .mmu_busy(mmu_busy),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] d);
        ld_we = 1'b1;
        ld_addr = 8'(i);
        ld_data = d;
        tick();
        ld_we = 1'b0;
        model[i] = d;
    endtask

    // Response monitor: every rising data_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (b1.data_valid && !dv_prev) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_dv", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_data", b1.data, e.data);
                check("sb_err", 32'(b1.rsp_err), 32'(e.err));
            end
        end
        dv_prev = b1.data_valid;
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee, input int m);
        int i;
        int j;
        sb.push_back('{ed, ee});
        b1.req_valid = 1'b1;
        b1.addr = a;
        mmu_busy = (m > 0);
        for (i = 1; i <= 40; i++) begin
            tick();
            if (i == m) mmu_busy = 1'b0;
            if (b1.grant) break;
        end
        check("grant_wait", i, m + 1);
        for (j = 1; j <= 40; j++) begin
            tick();
            if (j == 1) check("grant_pulse", 32'(b1.grant), 0);
            if (b1.data_valid) break;
        end
        check("dv_latency", j, 2);
        tick();
        check("hold_dv", 32'(b1.data_valid), 1);
        check("hold_data", b1.data, ed);
        check("hold_err", 32'(b1.rsp_err), 32'(ee));
        tick();
        b1.req_valid = 1'b0;
        tick();
        check("release_dv", 32'(b1.data_valid), 0);
        check("release_err", 32'(b1.rsp_err), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b1.req_valid = 1'b0;
        b1.addr = '0;
        b2.req_valid = 1'b0;
        b2.addr = '0;
        repeat (3) tick();
        check("rst_grant", 32'(b1.grant), 0);
        check("rst_dv", 32'(b1.data_valid), 0);
        check("rst_err", 32'(b1.rsp_err), 0);
        check("rst_data", b1.data, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) load(i, 32'h1357_0000 + i * 32'h0000_0103);
        load(5, 32'hDEAD_BEEF);
        tick();

        vecs[0] = '{32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[1] = '{32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 5};
        vecs[2] = '{32'h0000_0400, NOP, 1'b1, 0};
        vecs[3] = '{32'h0000_0002, NOP, 1'b1, 0};
        vecs[4] = '{32'h0000_03FC, model[255], 1'b0, 0};
        vecs[5] = '{32'h0000_0000, model[0], 1'b0, 0};
        vecs[6] = '{32'hFFFF_FFFC, NOP, 1'b1, 0};
        vecs[7] = '{32'h0000_0401, NOP, 1'b1, 0};
        vecs[8] = '{32'h0000_0020, model[8], 1'b0, 2};
        for (int k = 0; k < 9; k++) fetch(vecs[k].addr, vecs[k].data, vecs[k].err, vecs[k].mmu);

        // Flush in BUSY: no response, then a normal request.
        b1.req_valid = 1'b1;
        b1.addr = 32'h8;
        tick();
        check("fl_grant", 32'(b1.grant), 1);
        tick();
        flush = 1'b1;
        b1.req_valid = 1'b0;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("fl_no_dv", 32'(b1.data_valid), 0);
            tick();
        end
        fetch(32'h8, model[2], 1'b0, 0);

        // Flush in IDLE blocks acceptance for that cycle only.
        sb.push_back('{model[6], 1'b0});
        b1.req_valid = 1'b1;
        b1.addr = 32'h18;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fli_no_grant", 32'(b1.grant), 0);
        tick();
        check("fli_grant", 32'(b1.grant), 1);
        tick();
        tick();
        check("fli_dv", 32'(b1.data_valid), 1);
        b1.req_valid = 1'b0;
        tick();
        check("fli_release", 32'(b1.data_valid), 0);
        tick();

        // Backdoor write on the same edge the array reads that word: old data returned.
        sb.push_back('{model[3], 1'b0});
        b1.req_valid = 1'b1;
        b1.addr = 32'hC;
        tick();
        check("rbw_grant", 32'(b1.grant), 1);
        tick();
        ld_we = 1'b1;
        ld_addr = 8'd3;
        ld_data = 32'h1234_5678;
        tick();
        ld_we = 1'b0;
        check("rbw_dv", 32'(b1.data_valid), 1);
        check("rbw_old", b1.data, 32'h1357_0000 + 3 * 32'h0000_0103);
        model[3] = 32'h1234_5678;
        b1.req_valid = 1'b0;
        tick();
        tick();
        fetch(32'hC, 32'h1234_5678, 1'b0, 0);

        // Reset in RESP drops the response silently.
        sb.push_back('{model[4], 1'b0});
        b1.req_valid = 1'b1;
        b1.addr = 32'h10;
        tick();
        tick();
        tick();
        check("rr_dv", 32'(b1.data_valid), 1);
        reset = 1'b1;
        b1.req_valid = 1'b0;
        tick();
        check("rr_dv_off", 32'(b1.data_valid), 0);
        check("rr_data", b1.data, 0);
        check("rr_err", 32'(b1.rsp_err), 0);
        reset = 1'b0;
        tick();
        fetch(32'h10, model[4], 1'b0, 0);

        // LATENCY=1 instance: grant at N+1, data_valid at N+2.
        b2.req_valid = 1'b1;
        b2.addr = 32'h14;
        tick();
        check("l1_grant", 32'(b2.grant), 1);
        check("l1_dv_early", 32'(b2.data_valid), 0);
        tick();
        check("l1_dv", 32'(b2.data_valid), 1);
        check("l1_grant_pulse", 32'(b2.grant), 0);
        check("l1_data", b2.data, 32'hDEAD_BEEF);
        b2.req_valid = 1'b0;
        tick();
        check("l1_release", 32'(b2.data_valid), 0);
        tick();

        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
